bus_arbiter_rr: RTL

- Round-robin arbiter for the shared tri-state system bus (BUS_addr/BUS_data/BUS_req/BUS_ready/BUS_RW) that the CPU ports and DMA masters contend for.
- Takes per-master request lines DMA[N-1:0] and returns a one-hot grant[N-1:0].
- Enforces a one-cycle turnaround between owners and a tenure limit so one master cannot starve the others.
- Runs a bus watchdog that reclaims the bus when a slave never returns BUS_ready.

---
 rtl/bus_arbiter_rr.sv | 118 +++++++++++
 1 files changed

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for the shared tri-state system bus.
// It adds a one-cycle turnaround between owners, a tenure limit and a watchdog on stuck transfers.
module bus_arbiter_rr #(
    parameter int N       = 8,
    parameter int TENURE  = 64,
    parameter int TIMEOUT = 256
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [N-1:0] DMA,
    output logic [N-1:0] grant,
    input  logic         BUS_req,
    input  logic         BUS_ready,
    output logic [2:0]   owner,
    output logic         bus_busy,
    output logic         timeout
);

    localparam int LW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = $clog2(TENURE + 1);
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

    state_t        state;
    logic [2:0]    last;
    logic [TW-1:0] tenure_cnt;
    logic [WW-1:0] wd_cnt;

    logic          found;
    logic [2:0]    sel;
    logic [LW-1:0] probe;
    logic          own_req;
    logic          other_req;
    logic          tenure_done;
    logic          wd_counting;
    logic          wd_fire;

    // First requester strictly after the previous owner, wrapping modulo N.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        probe = '0;
        for (int i = 1; i <= N; i++) begin
            probe = LW'((int'(last) + i) % N);
            if (!found && DMA[probe]) begin
                found = 1'b1;
                sel   = 3'(probe);
            end
        end
    end

    // In OWN the grant vector is the owner mask, so it separates the owner from its rivals.
    assign own_req     = |(DMA & grant);
    assign other_req   = |(DMA & ~grant);
    // The counter holds completed cycles, and the coming edge completes one more.
    assign tenure_done = (tenure_cnt >= TW'(TENURE - 1));
    assign wd_counting = BUS_req && !BUS_ready;
    assign wd_fire     = wd_counting && (wd_cnt == WW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state      <= IDLE;
            grant      <= '0;
            owner      <= '0;
            bus_busy   <= 1'b0;
            timeout    <= 1'b0;
            last       <= 3'(N - 1);
            tenure_cnt <= '0;
            wd_cnt     <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    grant    <= '0;
                    bus_busy <= 1'b0;
                    wd_cnt   <= '0;
                    if (found) begin
                        grant      <= N'(1) << sel;
                        owner      <= sel;
                        last       <= sel;
                        bus_busy   <= 1'b1;
                        tenure_cnt <= '0;
                        state      <= OWN;
                    end
                end
                OWN: begin
                    if (tenure_cnt != TW'(TENURE))
                        tenure_cnt <= tenure_cnt + 1'b1;
                    wd_cnt <= wd_counting ? wd_cnt + 1'b1 : '0;
                    // The watchdog wins, and otherwise the bus is only handed back between transfers.
                    if (wd_fire) begin
                        timeout  <= 1'b1;
                        grant    <= '0;
                        bus_busy <= 1'b0;
                        wd_cnt   <= '0;
                        state    <= GAP;
                    end else if (!BUS_req && (!own_req || (tenure_done && other_req))) begin
                        grant    <= '0;
                        bus_busy <= 1'b0;
                        state    <= GAP;
                    end
                end
                GAP: begin
                    grant    <= '0;
                    bus_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    grant    <= '0;
                    bus_busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
